icache_assoc: RTL and testbench

//  Parametrised N-way set-associative instruction cache between the CPU fetch stage and the MMU burst port.

---
 rtl/icache_pkg.sv | 30 +++
 rtl/icache_way.sv | 49 ++++
 rtl/icache_assoc.sv | 228 ++++++++++++++++++++++
 tb/tb_icache_assoc.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL
  } icache_state_t;

  function automatic int calc_off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int calc_idx_w(input int sets);
    return $clog2(sets);
  endfunction

  // Word addresses are 30 bits; the tag is whatever index and offset leave over.
  function automatic int calc_tag_w(input int sets, input int line_words);
    return 30 - $clog2(sets) - $clog2(line_words);
  endfunction

  localparam int DEF_WAYS       = 2;
  localparam int DEF_SETS       = 128;
  localparam int DEF_LINE_WORDS = 16;
  localparam int DEF_OFF_W      = calc_off_w(DEF_LINE_WORDS);
  localparam int DEF_IDX_W      = calc_idx_w(DEF_SETS);
  localparam int DEF_TAG_W      = calc_tag_w(DEF_SETS, DEF_LINE_WORDS);

endpackage

// File: rtl/icache_way.sv
// One cache way: tag and line storage with combinational read and registered write,
// plus per-set valid bits with a synchronous clear-all.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int TAG_W      = DEF_TAG_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(SETS)-1:0]      rd_idx,
  output logic                         rd_valid,
  output logic [TAG_W-1:0]             rd_tag,
  output logic [LINE_WORDS*32-1:0]     rd_line,
  input  logic                         wr_en,
  input  logic [$clog2(SETS)-1:0]      wr_idx,
  input  logic [TAG_W-1:0]             wr_tag,
  input  logic [LINE_WORDS*32-1:0]     wr_line,
  input  logic                         clr_all
);

  logic [TAG_W-1:0]         tag_mem  [SETS];
  logic [LINE_WORDS*32-1:0] data_mem [SETS];
  logic [SETS-1:0]          valid_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_line;
    end
  end

  // Clear-all beats a same-cycle fill so a flush can never leave a line behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (clr_all) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = data_mem[rd_idx];

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache: zero-latency hits, full-line refill from the
// MMU burst port with critical-word bypass, flush and per-set round-robin replacement.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int WAYS       = DEF_WAYS,
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_en,
  input  logic [31:0] inst_addr,
  input  logic        flush,
  output logic [31:0] inst_data,
  output logic        inst_ok,
  output logic [31:0] inst_addr_mmu,
  output logic        inst_read_req,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_read_data,
  input  logic        mmu_valid,
  input  logic        mmu_last
);

  localparam int OFF_W = calc_off_w(LINE_WORDS);
  localparam int IDX_W = calc_idx_w(SETS);
  localparam int TAG_W = calc_tag_w(SETS, LINE_WORDS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  icache_state_t    state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [OFF_W-1:0] beat_q, beat_d;
  logic [WAY_W-1:0] vic_q, vic_d;
  logic             flush_pend_q, flush_pend_d;
  logic [31:0]      line_buf_q [LINE_WORDS];
  logic [WAY_W-1:0] rr_q [SETS];

  logic [31:0]      cur_addr;
  logic [IDX_W-1:0] cur_idx;
  logic [TAG_W-1:0] cur_tag;
  logic [OFF_W-1:0] cur_off;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  logic [OFF_W-1:0] req_off;
  logic             unused_addr_bits;

  logic [WAYS-1:0]          way_valid;
  logic [WAYS-1:0]          way_hit;
  logic [TAG_W-1:0]         way_tag  [WAYS];
  logic [LINE_WORDS*32-1:0] way_line [WAYS];
  logic [LINE_WORDS*32-1:0] fill_line;

  logic             hit;
  logic [31:0]      hit_word;
  logic [WAY_W-1:0] vic_sel;
  logic             vic_found;
  logic [31:0]      req_word;

  logic        ok_c, req_c, fill_we, clr_all, rr_adv, buf_we;
  logic [31:0] data_c, mmu_addr_c;

  // While a miss is outstanding the fetch address is taken from the latched copy.
  assign cur_addr = (state_q == IDLE) ? inst_addr : addr_q;
  assign cur_idx  = cur_addr[IDX_W+OFF_W+1:OFF_W+2];
  assign cur_tag  = cur_addr[31:32-TAG_W];
  assign cur_off  = cur_addr[OFF_W+1:2];
  assign wr_idx   = addr_q[IDX_W+OFF_W+1:OFF_W+2];
  assign wr_tag   = addr_q[31:32-TAG_W];
  assign req_off  = addr_q[OFF_W+1:2];
  assign unused_addr_bits = ^cur_addr[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      icache_way #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
      ) u_way (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (cur_idx),
        .rd_valid (way_valid[gi]),
        .rd_tag   (way_tag[gi]),
        .rd_line  (way_line[gi]),
        .wr_en    (fill_we && (vic_q == WAY_W'(gi))),
        .wr_idx   (wr_idx),
        .wr_tag   (wr_tag),
        .wr_line  (fill_line),
        .clr_all  (clr_all)
      );
      assign way_hit[gi] = way_valid[gi] && (way_tag[gi] == cur_tag);
    end

    // The beat arriving this cycle is not yet in the buffer, so splice it in directly.
    for (gi = 0; gi < LINE_WORDS; gi++) begin : g_fill
      assign fill_line[gi*32 +: 32] = (beat_q == OFF_W'(gi)) ? inst_read_data : line_buf_q[gi];
    end
  endgenerate

  always_comb begin
    hit      = 1'b0;
    hit_word = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_hit[w]) begin
        hit      = 1'b1;
        hit_word = way_line[w][cur_off*32 +: 32];
      end
    end
  end

  always_comb begin
    vic_sel   = rr_q[cur_idx];
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!vic_found && !way_valid[w]) begin
        vic_sel   = WAY_W'(w);
        vic_found = 1'b1;
      end
    end
  end

  assign req_word = (beat_q == req_off) ? inst_read_data : line_buf_q[req_off];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    beat_d       = beat_q;
    vic_d        = vic_q;
    flush_pend_d = flush_pend_q;
    ok_c         = 1'b0;
    data_c       = '0;
    req_c        = 1'b0;
    mmu_addr_c   = '0;
    fill_we      = 1'b0;
    clr_all      = 1'b0;
    rr_adv       = 1'b0;
    buf_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        clr_all = flush;
        if (inst_en) begin
          if (hit) begin
            ok_c   = 1'b1;
            data_c = hit_word;
          end else begin
            req_c      = 1'b1;
            mmu_addr_c = {inst_addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
            addr_d     = inst_addr;
            if (inst_addr_ok) begin
              state_d = REFILL;
              beat_d  = '0;
              vic_d   = vic_sel;
            end else begin
              state_d = REQ;
            end
          end
        end
      end
      REQ: begin
        req_c      = 1'b1;
        mmu_addr_c = {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        if (flush) flush_pend_d = 1'b1;
        if (inst_addr_ok) begin
          state_d = REFILL;
          beat_d  = '0;
          vic_d   = vic_sel;
        end
      end
      REFILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (mmu_valid) begin
          buf_we = 1'b1;
          beat_d = beat_q + 1'b1;
          if (mmu_last) begin
            ok_c         = 1'b1;
            data_c       = req_word;
            rr_adv       = 1'b1;
            state_d      = IDLE;
            flush_pend_d = 1'b0;
            // A short burst leaves the victim untouched rather than installing a partial line.
            if (flush_pend_q || flush) begin
              clr_all = 1'b1;
            end else if (beat_q == OFF_W'(LINE_WORDS - 1)) begin
              fill_we = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      vic_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beat_q       <= beat_d;
      vic_q        <= vic_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (rr_adv) begin
      rr_q[wr_idx] <= (rr_q[wr_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[wr_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) line_buf_q[beat_q] <= inst_read_data;
  end

  // Reset forces every output low even though the FSM logic is purely combinational.
  assign inst_ok       = ok_c & ~rst;
  assign inst_read_req = req_c & ~rst;
  assign inst_data     = rst ? '0 : data_c;
  assign inst_addr_mmu = rst ? '0 : mmu_addr_c;

endmodule

// File: tb/tb_icache_assoc.sv
// Self-checking bench for icache_assoc: directed corner cases, a vector table and a
// randomized run against a per-set reference model of tags, data and replacement.
module tb_icache_assoc;

  localparam int W  = 2;
  localparam int S  = 128;
  localparam int LW = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_en;
  logic [31:0] inst_addr;
  logic        flush;
  logic [31:0] inst_data;
  logic        inst_ok;
  logic [31:0] inst_addr_mmu;
  logic        inst_read_req;
  logic        inst_addr_ok;
  logic [31:0] inst_read_data;
  logic        mmu_valid;
  logic        mmu_last;

  icache_assoc #(.WAYS(W), .SETS(S), .LINE_WORDS(LW)) dut (
    .clk            (clk),
    .rst            (rst),
    .inst_en        (inst_en),
    .inst_addr      (inst_addr),
    .flush          (flush),
    .inst_data      (inst_data),
    .inst_ok        (inst_ok),
    .inst_addr_mmu  (inst_addr_mmu),
    .inst_read_req  (inst_read_req),
    .inst_addr_ok   (inst_addr_ok),
    .inst_read_data (inst_read_data),
    .mmu_valid      (mmu_valid),
    .mmu_last       (mmu_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pat      = 0;

  // Reference model: per set, W slots of {valid, tag, line} plus a replacement pointer.
  bit          m_valid [S][W];
  logic [18:0] m_tag   [S][W];
  logic [31:0] m_data  [S][W][LW];
  int          m_rr    [S];

  typedef struct {
    logic [31:0] addr;
    bit          exp_hit;
    logic [31:0] exp_data;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < S; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < W; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_flush();
    for (int s = 0; s < S; s++)
      for (int w = 0; w < W; w++) m_valid[s][w] = 1'b0;
  endtask

  function automatic int m_lookup(input logic [31:0] a);
    for (int w = 0; w < W; w++)
      if (m_valid[a[12:6]][w] && m_tag[a[12:6]][w] == a[31:13]) return w;
    return -1;
  endfunction

  function automatic logic [31:0] beat_word(input logic [31:0] line, input int b);
    logic [31:0] bb;
    bb = b;
    if (pat == 0) return 32'hA0 + bb;
    return line ^ (bb * 32'h9E3779B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    inst_en = 1'b0;
    #1;
    @(negedge clk);
    flush = 1'b0;
    model_flush();
    $display("flush (idle)");
  endtask

  // One fetch, driven cycle by cycle; the model decides whether it must hit.
  task automatic fetch(input logic [31:0] addr, input int ok_delay, input int flush_beat,
                       input int nbeats, input int rst_beat, input bit gaps,
                       output bit was_hit, output logic [31:0] got);
    logic [6:0]  set;
    logic [18:0] tag;
    logic [3:0]  off;
    logic [31:0] line;
    logic [31:0] beats [LW];
    int mw, b, cyc, v;
    bit flushed;
    set = addr[12:6];
    tag = addr[31:13];
    off = addr[5:2];
    line = {addr[31:6], 6'd0};
    mw = m_lookup(addr);
    flushed = 1'b0;
    got = '0;
    for (int i = 0; i < LW; i++) beats[i] = '0;
    @(negedge clk);
    inst_en = 1'b1;
    inst_addr = addr;
    inst_addr_ok = (ok_delay == 0);
    #1;
    was_hit = inst_ok;
    if (mw >= 0) begin
      chk("hit_ok", {31'd0, inst_ok}, 32'd1);
      chk("hit_data", inst_data, m_data[set][mw][off]);
      chk("hit_noreq", {31'd0, inst_read_req}, 32'd0);
      got = inst_data;
      $display("fetch %h hit  data %h", addr, got);
      @(negedge clk);
      inst_en = 1'b0;
      inst_addr_ok = 1'b0;
      return;
    end
    chk("miss_ok", {31'd0, inst_ok}, 32'd0);
    chk("miss_req", {31'd0, inst_read_req}, 32'd1);
    chk("miss_addr", inst_addr_mmu, line);
    for (int c = 1; c <= ok_delay; c++) begin
      @(negedge clk);
      inst_addr_ok = (c == ok_delay);
      if (gaps) begin
        mmu_valid = 1'($urandom_range(0, 1));
        inst_read_data = $urandom;
      end
      #1;
      chk("req_hold", {31'd0, inst_read_req}, 32'd1);
      chk("req_addr", inst_addr_mmu, line);
      chk("req_ok", {31'd0, inst_ok}, 32'd0);
    end
    @(negedge clk);
    inst_addr_ok = 1'b0;
    mmu_valid = 1'b0;
    b = 0;
    cyc = 0;
    while (b < nbeats) begin
      cyc++;
      if (b == rst_beat) begin
        rst = 1'b1;
        mmu_valid = 1'b1;
        mmu_last = 1'b1;
        inst_read_data = beat_word(line, b);
        #1;
        chk("rst_ok", {31'd0, inst_ok}, 32'd0);
        chk("rst_req", {31'd0, inst_read_req}, 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_mmu_addr", inst_addr_mmu, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        inst_en = 1'b0;
        mmu_valid = 1'b0;
        mmu_last = 1'b0;
        model_reset();
        $display("fetch %h reset at beat %0d", addr, b);
        return;
      end
      if (gaps && cyc < 100 && $urandom_range(0, 2) == 0) begin
        mmu_valid = 1'b0;
        mmu_last = 1'b0;
        flush = 1'b0;
        #1;
        chk("gap_ok", {31'd0, inst_ok}, 32'd0);
        chk("gap_req", {31'd0, inst_read_req}, 32'd0);
        @(negedge clk);
        continue;
      end
      mmu_valid = 1'b1;
      inst_read_data = beat_word(line, b);
      beats[b] = inst_read_data;
      mmu_last = (b == nbeats - 1);
      flush = (b == flush_beat);
      if (flush) flushed = 1'b1;
      #1;
      if (mmu_last) begin
        chk("fill_ok", {31'd0, inst_ok}, 32'd1);
        if (off < nbeats) chk("fill_data", inst_data, beats[off]);
        got = inst_data;
      end else begin
        chk("beat_ok", {31'd0, inst_ok}, 32'd0);
        chk("beat_req", {31'd0, inst_read_req}, 32'd0);
      end
      @(negedge clk);
      b++;
    end
    mmu_valid = 1'b0;
    mmu_last = 1'b0;
    flush = 1'b0;
    inst_en = 1'b0;
    v = -1;
    for (int w = 0; w < W; w++) if (!m_valid[set][w] && v < 0) v = w;
    if (v < 0) v = m_rr[set];
    m_rr[set] = (m_rr[set] + 1) % W;
    if (flushed) begin
      model_flush();
    end else if (nbeats == LW) begin
      m_valid[set][v] = 1'b1;
      m_tag[set][v] = tag;
      for (int i = 0; i < LW; i++) m_data[set][v][i] = beats[i];
    end
    $display("fetch %h miss data %h beats %0d%s", addr, got, nbeats, flushed ? " flushed" : "");
  endtask

  initial begin
    bit          h;
    logic [31:0] d;
    logic [31:0] ra;
    int          fb, nb;

    tbl[0] = '{32'h0000_0000, 1'b0, 32'hA0};
    tbl[1] = '{32'h0000_2000, 1'b0, 32'hA0};
    tbl[2] = '{32'h0000_0004, 1'b1, 32'hA1};
    tbl[3] = '{32'h0000_2008, 1'b1, 32'hA2};
    tbl[4] = '{32'h0000_4000, 1'b0, 32'hA0};
    tbl[5] = '{32'h0000_2000, 1'b1, 32'hA0};
    tbl[6] = '{32'h0000_0000, 1'b0, 32'hA0};

    rst = 1'b1;
    inst_en = 1'b1;
    inst_addr = 32'h0000_1044;
    flush = 1'b0;
    inst_addr_ok = 1'b0;
    inst_read_data = '0;
    mmu_valid = 1'b0;
    mmu_last = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("reset_ok", {31'd0, inst_ok}, 32'd0);
    chk("reset_req", {31'd0, inst_read_req}, 32'd0);
    chk("reset_data", inst_data, 32'd0);
    chk("reset_mmu_addr", inst_addr_mmu, 32'd0);
    @(negedge clk);
    inst_en = 1'b0;
    rst = 1'b0;

    // Cold miss, then zero-latency hit on the same word.
    fetch(32'h0000_1044, 2, -1, LW, -1, 1'b0, h, d);
    chk("cold_hit_flag", {31'd0, h}, 32'd0);
    chk("cold_data", d, 32'hA1);
    fetch(32'h0000_1044, 1, -1, LW, -1, 1'b0, h, d);
    chk("rehit_flag", {31'd0, h}, 32'd1);
    chk("rehit_data", d, 32'hA1);

    // Flush in IDLE invalidates the line.
    flush_pulse();
    fetch(32'h0000_1044, 1, -1, LW, -1, 1'b0, h, d);
    chk("flush_miss", {31'd0, h}, 32'd0);

    // Associativity and round-robin eviction in set 0.
    for (int i = 0; i < 7; i++) begin
      fetch(tbl[i].addr, 1, -1, LW, -1, 1'b0, h, d);
      chk("tbl_hit", {31'd0, h}, {31'd0, tbl[i].exp_hit});
      chk("tbl_data", d, tbl[i].exp_data);
    end

    // Flush during refill: word delivered, line never validated.
    fetch(32'h0000_5048, 1, 5, LW, -1, 1'b0, h, d);
    chk("midflush_data", d, 32'hA2);
    fetch(32'h0000_5048, 1, -1, LW, -1, 1'b0, h, d);
    chk("midflush_refetch", {31'd0, h}, 32'd0);

    // Address accepted in the miss cycle; requested word is the final beat.
    fetch(32'h0000_307C, 0, -1, LW, -1, 1'b0, h, d);
    chk("b2b_miss", {31'd0, h}, 32'd0);
    chk("b2b_data", d, 32'hAF);
    fetch(32'h0000_307C, 0, -1, LW, -1, 1'b0, h, d);
    chk("b2b_rehit", {31'd0, h}, 32'd1);

    // Early mmu_last: word delivered from the partial line, line left invalid.
    fetch(32'h0000_6044, 1, -1, 8, -1, 1'b0, h, d);
    chk("short_data", d, 32'hA1);
    fetch(32'h0000_6044, 1, -1, LW, -1, 1'b0, h, d);
    chk("short_refetch", {31'd0, h}, 32'd0);

    // Reset in the middle of a burst wipes everything.
    fetch(32'h0000_1044, 1, -1, LW, 8, 1'b0, h, d);
    fetch(32'h0000_307C, 1, -1, LW, -1, 1'b0, h, d);
    chk("post_rst_miss", {31'd0, h}, 32'd0);

    // Randomized traffic over a few sets and conflicting tags.
    pat = 1;
    for (int n = 0; n < 300; n++) begin
      ra = ($urandom_range(0, 5) << 13) | ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
      fb = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1;
      nb = ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 15)) : LW;
      if ($urandom_range(0, 19) == 0) flush_pulse();
      fetch(ra, int'($urandom_range(0, 3)), fb, nb, -1, 1'b1, h, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
